sun_sar9b_ctrl: RTL and testbench
=================================

Name: sun_sar9b_ctrl

Overview:
- Synchronous controller and data reader for the 9-bit asynchronous SAR ADC macro.
- Generates the sampling clocks and enable for each conversion.
- Detects the macro's asynchronous DONE through a synchronizer and captures D[8:0].
- Presents each result on a valid/ready stream, with sticky overflow and timeout flags for the system register file.

Parameters:
- SAMPLE_CYCLES, 4: CK cycles CK_SAMPLE is held high per conversion; legal range 2..255.
- TIMEOUT_CYCLES, 32: CK cycles allowed in CONV for a DONE rising edge; legal range 4..1023.
- TWOS, 0: output format. 0 = offset binary, DOUT=D. 1 = two's complement, DOUT = {~D[8], D[7:0]}.

Ports:
- CK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- START  input  1  single-cycle request for one conversion; sampled in IDLE only.
- CONT  input  1  continuous mode; while high, a new conversion starts automatically after each capture or timeout.
- CLR_ERR  input  1  clears OVERFLOW and TIMEOUT.
- DONE  input  1  asynchronous end-of-conversion from the ADC macro.
- D  input  9  ADC result; stable while DONE is high.
- CK_SAMPLE  output  1  sampling clock to the ADC.
- CK_SAMPLE_BSSW  output  1  bootstrapped-switch sampling clock to the ADC.
- EN  output  1  ADC enable.
- DOUT  output  9  captured result.
- DOUT_VALID  output  1  DOUT holds an unconsumed result.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID and DOUT_READY are both high.
- BUSY  output  1  high in any state other than IDLE.
- OVERFLOW  output  1  sticky; a result was dropped.
- TIMEOUT  output  1  sticky; a conversion timed out.

Behaviour:
- Clock and reset: single clock CK. RST is synchronous, active-high. All outputs are registered.
- Reset values:
  - State goes to IDLE.
  - CK_SAMPLE, CK_SAMPLE_BSSW, EN, BUSY, DOUT_VALID, OVERFLOW, TIMEOUT are 0.
  - DOUT is 0. Counters are 0. Synchronizer flops are 0.
  - RST mid-conversion aborts immediately; nothing is captured.
- DONE synchronizer and edge detect:
  - Two-flop synchronizer produces done_s; done_q is done_s delayed one cycle.
  - A rising edge is done_s=1 and done_q=0.
  - D is not synchronized. It is sampled only on the edge cycle, which is at least 2 cycles after DONE asserted.
- State machine:
  - IDLE:
    - Outputs: EN=0, CK_SAMPLE=0, CK_SAMPLE_BSSW=0.
    - If START or CONT is high at cycle t, go to SAMPLE at t+1.
  - SAMPLE:
    - EN=1 and CK_SAMPLE=1 for exactly SAMPLE_CYCLES cycles.
    - CK_SAMPLE_BSSW=1 for the first SAMPLE_CYCLES-1 of those cycles, so it falls one cycle before CK_SAMPLE.
    - Then go to CONV.
  - CONV:
    - Outputs: EN=1, CK_SAMPLE=0, CK_SAMPLE_BSSW=0.
    - The timeout counter starts at 0 on entry.
    - On a DONE rising edge: capture D and go to IDLE, or directly to SAMPLE if CONT=1.
    - If the counter reaches TIMEOUT_CYCLES-1 with no edge: set TIMEOUT, discard the result, then go to IDLE, or SAMPLE if CONT=1.
    - DONE already high on CONV entry (stuck) produces no edge and therefore times out.
- Capture and handshake:
  - DOUT_VALID=0, or DOUT_VALID=1 with DOUT_READY=1 on the capture cycle: DOUT is loaded with the formatted D and DOUT_VALID=1 next cycle.
  - DOUT_VALID=1 with DOUT_READY=0 on the capture cycle: the new result is dropped, DOUT is unchanged, OVERFLOW is set.
  - DOUT_VALID clears the cycle after DOUT_VALID and DOUT_READY are both high, unless a capture occurs on that same cycle.
- Sticky flags: CLR_ERR clears OVERFLOW and TIMEOUT next cycle. A set event in the same cycle as CLR_ERR wins.
- START and CONT: START outside IDLE is ignored. Dropping CONT mid-conversion completes the current conversion, then returns to IDLE.
- Latency: START at cycle t gives CK_SAMPLE high over t+1..t+SAMPLE_CYCLES, CONV from t+SAMPLE_CYCLES+1. DONE rising at cycle c gives DOUT_VALID high at c+3 (c+1, c+2 synchronizer; edge detected at c+2; register load at c+3).

Test Plan:
- Reset, then START pulse with SAMPLE_CYCLES=4 -> CK_SAMPLE high exactly 4 cycles, CK_SAMPLE_BSSW high 3 cycles starting on the same edge, EN high from SAMPLE entry until capture, BUSY mirrors the non-IDLE states.
- Model DONE rising 5 cycles into CONV with D=9'h15A, TWOS=0 -> DOUT=9'h15A, DOUT_VALID high 3 cycles after DONE; with TWOS=1 -> DOUT=9'h05A.
- CONT=1, DOUT_READY=1, model returns 9'h001, 9'h1FF, 9'h100 -> three back-to-back results in order, SAMPLE re-entered directly from CONV, OVERFLOW stays 0.
- DOUT_READY held 0, two conversions (D=9'h0AA then 9'h155) -> DOUT stays 9'h0AA, OVERFLOW=1; CLR_ERR pulse -> OVERFLOW=0.
- DONE held low (TIMEOUT_CYCLES=32) -> TIMEOUT=1 after 32 CONV cycles, no DOUT_VALID, return to IDLE; repeat with DONE stuck high -> same result.
- RST asserted in the 2nd CONV cycle -> next cycle all outputs at reset values; a later DONE edge is not captured.

Source files
------------

// File: rtl/sun_sar9b_ctrl_if.sv
// Result stream from the SAR controller: registered DOUT with a valid/ready handshake.
interface sun_sar9b_ctrl_if;
  logic [8:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/sun_sar9b_ctrl.sv
// Sequencer and reader for the 9-bit async SAR ADC: drives sample clocks/enable,
// synchronises DONE, captures D onto a valid/ready stream with sticky error flags.
module sun_sar9b_ctrl #(
  parameter int SAMPLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter bit TWOS           = 1'b0
) (
  input  logic                   ck_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic                   clr_err_i,
  input  logic                   done_i,
  input  logic [8:0]             d_i,
  output logic                   ck_sample_o,
  output logic                   ck_sample_bssw_o,
  output logic                   en_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   timeout_o,
  sun_sar9b_ctrl_if.master       dout_if
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_e;

  localparam logic [9:0] SMP_LAST = 10'(SAMPLE_CYCLES - 1);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       sync1_q, done_s_q, done_q;
  logic       ck_sample_q, ck_sample_d;
  logic       bssw_q, bssw_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       ovf_q, ovf_d;
  logic       tmo_q, tmo_d;
  logic       valid_q, valid_d;
  logic [8:0] dout_q, dout_d;

  logic       done_rise, conv_done, conv_tmo, accept;
  logic [8:0] d_fmt;

  // Only a rising edge counts, so a DONE already high on CONV entry ends in timeout.
  assign done_rise = done_s_q & ~done_q;
  assign conv_done = (state_q == CONV) && done_rise;
  assign conv_tmo  = (state_q == CONV) && !done_rise && (cnt_q == TMO_LAST);
  assign accept    = !valid_q || dout_if.dout_ready;
  assign d_fmt     = TWOS ? {~d_i[8], d_i[7:0]} : d_i;

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      done_s_q    <= 1'b0;
      done_q      <= 1'b0;
      ck_sample_q <= 1'b0;
      bssw_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= done_i;
      done_s_q    <= sync1_q;
      done_q      <= done_s_q;
      ck_sample_q <= ck_sample_d;
      bssw_q      <= bssw_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
    end
  end

  // One counter serves both the SAMPLE length and the CONV timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i || cont_i) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == SMP_LAST) begin
          state_d = CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      CONV: begin
        if (conv_done || conv_tmo) begin
          state_d = cont_i ? SAMPLE : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_comb begin
    ck_sample_d = (state_d == SAMPLE);
    bssw_d      = (state_d == SAMPLE) && (cnt_d != SMP_LAST);
    en_d        = (state_d != IDLE);
    busy_d      = (state_d != IDLE);

    dout_d  = dout_q;
    valid_d = valid_q;
    if (valid_q && dout_if.dout_ready) valid_d = 1'b0;
    if (conv_done && accept) begin
      dout_d  = d_fmt;
      valid_d = 1'b1;
    end

    ovf_d = ovf_q;
    tmo_d = tmo_q;
    if (clr_err_i) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (conv_done && !accept) ovf_d = 1'b1;
    if (conv_tmo)             tmo_d = 1'b1;
  end

  assign ck_sample_o        = ck_sample_q;
  assign ck_sample_bssw_o   = bssw_q;
  assign en_o               = en_q;
  assign busy_o             = busy_q;
  assign overflow_o         = ovf_q;
  assign timeout_o          = tmo_q;
  assign dout_if.dout       = dout_q;
  assign dout_if.dout_valid = valid_q;

endmodule

// File: tb/tb_sun_sar9b_ctrl.sv
// Bench for sun_sar9b_ctrl: offset-binary and two's-complement instances share stimulus;
// a reactive ADC model pushes expected results, a stream monitor pops them on handshake.
module tb_sun_sar9b_ctrl;
  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cont = 1'b0, clr_err = 1'b0, done = 1'b0, ready = 1'b0;
  logic [8:0] d_in = '0;

  logic ck_sample0, bssw0, en0, busy0, ovf0, tmo0;
  logic ck_sample1, bssw1, en1, busy1, ovf1, tmo1;

  sun_sar9b_ctrl_if if0 ();
  sun_sar9b_ctrl_if if1 ();
  assign if0.dout_ready = ready;
  assign if1.dout_ready = ready;

  sun_sar9b_ctrl #(.SAMPLE_CYCLES(4), .TIMEOUT_CYCLES(32), .TWOS(1'b0)) u_dut0 (
    .ck_i(ck), .rst_i(rst), .start_i(start), .cont_i(cont), .clr_err_i(clr_err),
    .done_i(done), .d_i(d_in), .ck_sample_o(ck_sample0), .ck_sample_bssw_o(bssw0),
    .en_o(en0), .busy_o(busy0), .overflow_o(ovf0), .timeout_o(tmo0), .dout_if(if0));

  sun_sar9b_ctrl #(.SAMPLE_CYCLES(4), .TIMEOUT_CYCLES(32), .TWOS(1'b1)) u_dut1 (
    .ck_i(ck), .rst_i(rst), .start_i(start), .cont_i(cont), .clr_err_i(clr_err),
    .done_i(done), .d_i(d_in), .ck_sample_o(ck_sample1), .ck_sample_bssw_o(bssw1),
    .en_o(en1), .busy_o(busy1), .overflow_o(ovf1), .timeout_o(tmo1), .dout_if(if1));

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit watch_busy = 1'b0;
  bit busy_dropped = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] f1(input logic [8:0] d);
    return {~d[8], d[7:0]};
  endfunction

  // Stream monitor: a result leaves on each valid&ready cycle, in order.
  always @(negedge ck) begin
    #2;
    if (!rst) begin
      if (if0.dout_valid && ready) begin
        if (q0.size() == 0) chk("sb0_extra", 32'd1, 32'd0);
        else                chk("sb0_dout", {23'd0, if0.dout}, {23'd0, q0.pop_front()});
      end
      if (if1.dout_valid && ready) begin
        if (q1.size() == 0) chk("sb1_extra", 32'd1, 32'd0);
        else                chk("sb1_dout", {23'd0, if1.dout}, {23'd0, q1.pop_front()});
      end
      if (watch_busy && !busy0) busy_dropped = 1'b1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  // ADC model: waits for the end of sampling, raises DONE dly cycles into CONV.
  task automatic adc_convert(input logic [8:0] d, input int dly, input bit push, input bit drop);
    int n;
    n = 0;
    while (!ck_sample0 && n < 200) begin @(negedge ck); n++; end
    if (n == 200) chk("tmo_sample_rise", 32'd0, 32'd1);
    n = 0;
    while (ck_sample0 && n < 200) begin @(negedge ck); n++; end
    if (n == 200) chk("tmo_sample_fall", 32'd0, 32'd1);
    repeat (dly - 1) @(negedge ck);
    done = 1'b1;
    d_in = d;
    if (push) begin
      q0.push_back(d);
      q1.push_back(f1(d));
    end
    if (drop) cont = 1'b0;
    repeat (3) @(negedge ck);
    done = 1'b0;
  endtask

  task automatic timeout_run(input string tag);
    logic v_seen;
    pulse_start();
    v_seen = if0.dout_valid;
    for (int k = 2; k <= 37; k++) begin
      @(negedge ck);
      v_seen |= if0.dout_valid;
      if (k == 36) chk({tag, "_pre"}, {30'd0, tmo0, busy0}, 32'b01);
      if (k == 37) chk({tag, "_post"}, {30'd0, tmo0, busy0}, 32'b10);
    end
    chk({tag, "_novalid"}, {31'd0, v_seen}, 32'd0);
  endtask

  initial begin
    logic [11:0] v_cks, v_bssw, v_en, v_busy, v_vld;
    int n;

    // Reset state
    repeat (3) @(negedge ck);
    chk("rst_outs", {19'd0, ck_sample0, bssw0, en0, busy0, ovf0, tmo0, if0.dout_valid, if0.dout},
        32'd0);
    rst = 1'b0;
    @(negedge ck);
    chk("idle_outs", {25'd0, ck_sample0, bssw0, en0, busy0, ovf0, tmo0, if0.dout_valid}, 32'd0);

    // Single conversion: waveform shape and DONE-to-valid latency
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge ck);
      v_cks[k-1]  = ck_sample0;
      v_bssw[k-1] = bssw0;
      v_en[k-1]   = en0;
      v_busy[k-1] = busy0;
      v_vld[k-1]  = if0.dout_valid;
      if (k == 1) start = 1'b0;
      if (k == 9) begin
        done = 1'b1;
        d_in = 9'h15A;
        q0.push_back(9'h15A);
        q1.push_back(f1(9'h15A));
      end
    end
    chk("ck_sample_win", {20'd0, v_cks}, 32'h00F);
    chk("bssw_win", {20'd0, v_bssw}, 32'h007);
    chk("en_win", {20'd0, v_en}, 32'h7FF);
    chk("busy_win", {20'd0, v_busy}, 32'h7FF);
    chk("valid_lat", {20'd0, v_vld}, 32'h800);
    chk("dout_obin", {23'd0, if0.dout}, 32'h15A);
    chk("dout_twos", {23'd0, if1.dout}, 32'h05A);
    ready = 1'b1;
    @(negedge ck);
    done = 1'b0;
    repeat (3) @(negedge ck);
    chk("valid_clr", {31'd0, if0.dout_valid}, 32'd0);

    // Continuous mode, back-to-back results
    cont = 1'b1;
    n = 0;
    while (!busy0 && n < 50) begin @(negedge ck); n++; end
    if (n == 50) chk("tmo_busy", 32'd0, 32'd1);
    watch_busy = 1'b1;
    adc_convert(9'h001, 5, 1'b1, 1'b0);
    adc_convert(9'h1FF, 3, 1'b1, 1'b0);
    watch_busy = 1'b0;
    adc_convert(9'h100, 6, 1'b1, 1'b1);
    chk("cont_no_idle", {31'd0, busy_dropped}, 32'd0);
    chk("cont_stop_idle", {31'd0, busy0}, 32'd0);
    chk("cont_no_ovf", {31'd0, ovf0}, 32'd0);
    repeat (2) @(negedge ck);
    chk("cont_drained", q0.size(), 32'd0);

    // Overflow with consumer stalled
    ready = 1'b0;
    pulse_start();
    adc_convert(9'h0AA, 5, 1'b1, 1'b0);
    pulse_start();
    adc_convert(9'h155, 4, 1'b0, 1'b0);
    chk("ovf_set", {30'd0, ovf0, ovf1}, 32'b11);
    chk("ovf_dout_keep", {23'd0, if0.dout}, 32'h0AA);
    chk("ovf_dout_keep1", {23'd0, if1.dout}, 32'h1AA);
    chk("ovf_valid", {31'd0, if0.dout_valid}, 32'd1);
    clr_err = 1'b1;
    @(negedge ck);
    clr_err = 1'b0;
    chk("ovf_clr", {31'd0, ovf0}, 32'd0);
    ready = 1'b1;
    repeat (3) @(negedge ck);
    chk("ovf_drained", q0.size(), 32'd0);

    // Timeouts: DONE held low, then stuck high
    timeout_run("tmo_low");
    clr_err = 1'b1;
    @(negedge ck);
    clr_err = 1'b0;
    chk("tmo_clr", {31'd0, tmo0}, 32'd0);
    done = 1'b1;
    d_in = 9'h1FF;
    repeat (3) @(negedge ck);
    timeout_run("tmo_stuck");
    done = 1'b0;
    repeat (3) @(negedge ck);

    // Reset in the second CONV cycle
    pulse_start();
    repeat (5) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    chk("rst_mid_outs", {19'd0, ck_sample0, bssw0, en0, busy0, ovf0, tmo0, if0.dout_valid, if0.dout},
        32'd0);
    @(negedge ck);
    done = 1'b1;
    d_in = 9'h077;
    repeat (6) @(negedge ck);
    chk("rst_no_capture", {29'd0, if0.dout_valid, busy0, en0}, 32'd0);
    done = 1'b0;
    repeat (2) @(negedge ck);

    chk("sb0_empty", q0.size(), 32'd0);
    chk("sb1_empty", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
